// File: rtl/reduce_accum_tree.sv
// reduce_accum_tree: N-lane vector sum. Each beat's lanes are reduced by a
// pipelined binary adder tree. The tree output is accumulated across the beats
// of a vector. On the last beat the total is fitted to OUT_W bits and presented
// through a valid/ready output register. One global stall freezes the whole
// pipeline while the output is held.
module reduce_accum_tree #(
  parameter int N      = 64,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter bit SIGNED = 1'b0,
  parameter bit SAT    = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*IN_W-1:0]   in_flat,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_ovf
);

  localparam int LVL   = $clog2(N);
  localparam int ACC_W = IN_W + LVL + 16;

  // number of operands present at tree level l (level 0 = input lanes)
  function automatic int cnt_at(input int l);
    int c;
    c = N;
    for (int k = 0; k < l; k++) c = (c + 1) / 2;
    return c;
  endfunction

  // start index of tree level l (l >= 1) inside the flattened node storage
  function automatic int off_at(input int l);
    int o;
    o = 0;
    for (int k = 1; k < l; k++) o += cnt_at(k);
    return o;
  endfunction

  localparam int TOT  = off_at(LVL + 1);
  localparam int ROOT = off_at(LVL);

  logic [ACC_W-1:0] lane_ext [N];
  logic [ACC_W-1:0] node_nxt [TOT];
  logic [ACC_W-1:0] node_q   [TOT];
  logic [LVL:1]     vld_q;
  logic [LVL:1]     lst_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] sum;
  logic [OUT_W-1:0] fit_data;
  logic             fit_ovf;
  logic             adv;

  // a held result stalls every stage at once, so nothing is lost or doubled
  assign in_ready = !out_valid || out_ready;
  assign adv      = in_ready;

  for (genvar i = 0; i < N; i++) begin : g_ext
    if (SIGNED) begin : g_sx
      assign lane_ext[i] = {{(ACC_W-IN_W){in_flat[i*IN_W+IN_W-1]}}, in_flat[i*IN_W +: IN_W]};
    end else begin : g_zx
      assign lane_ext[i] = {{(ACC_W-IN_W){1'b0}}, in_flat[i*IN_W +: IN_W]};
    end
  end

  // pairwise adders; an unpaired operand at the end of a level passes through
  for (genvar l = 1; l <= LVL; l++) begin : g_lvl
    localparam int C  = cnt_at(l);
    localparam int PC = cnt_at(l - 1);
    localparam int O  = off_at(l);
    localparam int PO = off_at(l - 1);
    for (genvar j = 0; j < C; j++) begin : g_node
      if (l == 1) begin : g_first
        if (2*j + 1 < PC) begin : g_add
          assign node_nxt[O+j] = lane_ext[2*j] + lane_ext[2*j+1];
        end else begin : g_pass
          assign node_nxt[O+j] = lane_ext[2*j];
        end
      end else begin : g_inner
        if (2*j + 1 < PC) begin : g_add
          assign node_nxt[O+j] = node_q[PO+2*j] + node_q[PO+2*j+1];
        end else begin : g_pass
          assign node_nxt[O+j] = node_q[PO+2*j];
        end
      end
    end
  end

  // tree registers with their valid/last sidebands, advancing only when not stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TOT; k++) node_q[k] <= '0;
      vld_q <= '0;
      lst_q <= '0;
    end else if (adv) begin
      for (int k = 0; k < TOT; k++) node_q[k] <= node_nxt[k];
      vld_q[1] <= in_valid;
      lst_q[1] <= in_valid & in_last;
      for (int l = 2; l <= LVL; l++) begin
        vld_q[l] <= vld_q[l-1];
        lst_q[l] <= lst_q[l-1];
      end
    end
  end

  assign sum = acc_q + node_q[ROOT];

  if (OUT_W >= ACC_W) begin : g_wide
    assign fit_ovf = 1'b0;
    if (SIGNED) begin : g_s
      assign fit_data = OUT_W'($signed(sum));
    end else begin : g_u
      assign fit_data = OUT_W'(sum);
    end
  end else begin : g_narrow
    logic [OUT_W-1:0] clamp;
    if (SIGNED) begin : g_s
      // in range only when all bits from OUT_W-1 upward agree with the sign
      logic [ACC_W-OUT_W:0] top;
      assign top     = sum[ACC_W-1:OUT_W-1];
      assign fit_ovf = !((&top) || !(|top));
      assign clamp   = sum[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin : g_u
      assign fit_ovf = |sum[ACC_W-1:OUT_W];
      assign clamp   = {OUT_W{1'b1}};
    end
    assign fit_data = (SAT && fit_ovf) ? clamp : sum[OUT_W-1:0];
  end

  // accumulate tree exits; the last beat of a vector publishes and restarts the sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      out_valid <= vld_q[LVL] & lst_q[LVL];
      if (vld_q[LVL]) begin
        if (lst_q[LVL]) begin
          out_data <= fit_data;
          out_ovf  <= fit_ovf;
          acc_q    <= '0;
        end else begin
          acc_q <= sum;
        end
      end
    end
  end

endmodule
